// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the slave data-path stages: burst encodings,
// response codes and the write-data FSM state type.
package axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI4 next-beat address calculator (FIXED / INCR / WRAP),
// shared by the write-data and read-data stages.
module axi4_burst_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] cur_addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        incr_addr = cur_addr + step;
        // Wrap window is the total burst length in bytes, always a power of two when legal.
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst_t'(burst))
            BURST_INCR: next_addr = incr_addr;
            BURST_WRAP: next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    next_addr = cur_addr;
        endcase
    end

endmodule

// File: rtl/axi4_slave_write_data.sv
// AXI4 slave write-data stage: latches one AW command per burst, writes W beats
// to a word-addressed memory port and hands ID/status to the response stage.
module axi4_slave_write_data
    import axi4_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          aw_cmd_valid,
    output logic                          aw_cmd_ready,
    input  logic [ID_WIDTH-1:0]           aw_id,
    input  logic [ADDR_WIDTH-1:0]         aw_addr,
    input  logic [7:0]                    aw_len,
    input  logic [2:0]                    aw_size,
    input  logic [1:0]                    aw_burst,
    input  logic                          wvalid,
    output logic                          wready,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH/8-1:0]       wstrb,
    input  logic                          wlast,
    output logic                          mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic [DATA_WIDTH/8-1:0]       mem_wstrb,
    input  logic                          b_resp_free,
    output logic                          b_transfer_done,
    output logic [ID_WIDTH-1:0]           b_bid_out,
    output logic [1:0]                    b_status_out
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BSHIFT = $clog2(BYTES);
    localparam int MA_W   = $clog2(MEM_DEPTH);

    state_t                 state_reg, state_next;
    logic [ID_WIDTH-1:0]    id_reg;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [7:0]             len_reg;
    logic [2:0]             size_reg;
    logic [1:0]             burst_reg;
    logic [7:0]             beat_cnt_reg;
    logic [1:0]             err_reg;
    logic [ID_WIDTH-1:0]    bid_reg;
    logic [1:0]             status_reg;
    logic                   done_reg;

    logic                   cmd_hs;
    logic                   beat_hs;
    logic                   cmd_err;
    logic [ADDR_WIDTH-1:0]  align_mask;
    logic [ADDR_WIDTH-1:0]  word_addr;
    logic [ADDR_WIDTH-1:0]  next_addr;
    logic                   in_range;
    logic                   cnt_at_len;
    logic                   end_beat;
    logic [1:0]             err_beat;

    axi4_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .cur_addr  (addr_reg),
        .size      (size_reg),
        .len       (len_reg),
        .burst     (burst_reg),
        .next_addr (next_addr)
    );

    // Command legality, evaluated on the incoming AW fields at latch time.
    always_comb begin
        align_mask = (ADDR_WIDTH'(1) << aw_size) - ADDR_WIDTH'(1);
        cmd_err    = (aw_size > 3'(BSHIFT))
                  || (aw_burst == BURST_RSVD)
                  || ((aw_burst == BURST_WRAP) && !wrap_len_ok(aw_len))
                  || ((aw_burst == BURST_WRAP) && ((aw_addr & align_mask) != '0));
    end

    always_comb begin
        word_addr  = addr_reg >> BSHIFT;
        in_range   = word_addr < ADDR_WIDTH'(MEM_DEPTH);
        cnt_at_len = (beat_cnt_reg == len_reg);
        cmd_hs     = aw_cmd_valid && aw_cmd_ready;
        beat_hs    = wvalid && wready;
        end_beat   = beat_hs && (wlast || cnt_at_len);

        // Protocol (SLVERR) outranks and may overwrite a pending DECERR.
        err_beat = err_reg;
        if (beat_hs) begin
            if (wlast != cnt_at_len)
                err_beat = RESP_SLVERR;
            else if ((err_reg == RESP_OKAY) && !in_range)
                err_beat = RESP_DECERR;
        end
    end

    always_comb begin
        state_next   = state_reg;
        aw_cmd_ready = 1'b0;
        wready       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                aw_cmd_ready = b_resp_free && !rst;
                if (aw_cmd_valid && b_resp_free && !rst)
                    state_next = ST_DATA;
            end
            ST_DATA: begin
                wready = 1'b1;
                if (end_beat)
                    state_next = ST_RESP;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_we    = beat_hs && (err_reg == RESP_OKAY) && in_range;
        mem_addr  = (state_reg == ST_DATA) ? word_addr[MA_W-1:0] : '0;
        mem_wdata = (state_reg == ST_DATA) ? wdata : '0;
        mem_wstrb = (state_reg == ST_DATA) ? wstrb : '0;
    end

    assign b_transfer_done = done_reg;
    assign b_bid_out       = bid_reg;
    assign b_status_out    = status_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            id_reg       <= '0;
            addr_reg     <= '0;
            len_reg      <= '0;
            size_reg     <= '0;
            burst_reg    <= '0;
            beat_cnt_reg <= '0;
            err_reg      <= RESP_OKAY;
            bid_reg      <= '0;
            status_reg   <= RESP_OKAY;
            done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= end_beat;
            if (cmd_hs) begin
                id_reg       <= aw_id;
                addr_reg     <= aw_addr;
                len_reg      <= aw_len;
                size_reg     <= aw_size;
                burst_reg    <= aw_burst;
                beat_cnt_reg <= '0;
                err_reg      <= cmd_err ? RESP_SLVERR : RESP_OKAY;
                bid_reg      <= '0;
                status_reg   <= RESP_OKAY;
            end else if (beat_hs) begin
                err_reg  <= err_beat;
                addr_reg <= next_addr;
                if (end_beat) begin
                    bid_reg    <= id_reg;
                    status_reg <= err_beat;
                end else begin
                    beat_cnt_reg <= beat_cnt_reg + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_slave_write_data.sv
// Directed bench for axi4_slave_write_data: burst addressing, error codes,
// response handoff timing, back-pressure from the response stage and mid-burst reset.
module tb_axi4_slave_write_data;

    logic        clk = 1'b0;
    logic        rst;
    logic        aw_cmd_valid;
    logic        aw_cmd_ready;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        b_resp_free;
    logic        b_transfer_done;
    logic [3:0]  b_bid_out;
    logic [1:0]  b_status_out;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    axi4_slave_write_data #(
        .ID_WIDTH   (4),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (1024)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .aw_cmd_valid    (aw_cmd_valid),
        .aw_cmd_ready    (aw_cmd_ready),
        .aw_id           (aw_id),
        .aw_addr         (aw_addr),
        .aw_len          (aw_len),
        .aw_size         (aw_size),
        .aw_burst        (aw_burst),
        .wvalid          (wvalid),
        .wready          (wready),
        .wdata           (wdata),
        .wstrb           (wstrb),
        .wlast           (wlast),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .b_resp_free     (b_resp_free),
        .b_transfer_done (b_transfer_done),
        .b_bid_out       (b_bid_out),
        .b_status_out    (b_status_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command and hold it until accepted (bounded wait).
    task automatic do_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        int n;
        @(negedge clk);
        aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
        aw_cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!aw_cmd_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("cmd_accept", {63'd0, aw_cmd_ready}, 64'd1);
        @(posedge clk);
        #1;
        aw_cmd_valid = 1'b0;
        $display("[TB] cmd id=%0h addr=%0h len=%0d size=%0d burst=%0d", id, addr, len, size, burst);
    endtask

    // One W beat; checks the memory port just before the accepting edge.
    task automatic do_beat(input string tag, input logic [31:0] data, input logic last,
                           input logic exp_we, input int exp_addr);
        @(negedge clk);
        wvalid = 1'b1; wdata = data; wstrb = 4'hF; wlast = last;
        #1;
        chk({tag, "_wready"}, {63'd0, wready}, 64'd1);
        chk({tag, "_we"}, {63'd0, mem_we}, {63'd0, exp_we});
        if (exp_we) begin
            chk({tag, "_addr"}, {54'd0, mem_addr}, 64'(exp_addr));
            chk({tag, "_wdata"}, {32'd0, mem_wdata}, {32'd0, data});
        end
        $display("[TB] beat %s data=%0h last=%0b we=%0b addr=%0d", tag, data, last, mem_we, mem_addr);
        @(posedge clk);
        #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    // Called right after the final beat's edge: expect the one-cycle done pulse.
    task automatic check_resp(input string tag, input logic [3:0] exp_bid, input logic [1:0] exp_st);
        @(negedge clk);
        chk({tag, "_done"}, {63'd0, b_transfer_done}, 64'd1);
        chk({tag, "_bid"}, {60'd0, b_bid_out}, {60'd0, exp_bid});
        chk({tag, "_status"}, {62'd0, b_status_out}, {62'd0, exp_st});
        chk({tag, "_wready_low"}, {63'd0, wready}, 64'd0);
        $display("[TB] resp %s bid=%0h status=%0b", tag, b_bid_out, b_status_out);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'd0, b_transfer_done}, 64'd0);
        chk({tag, "_bid_hold"}, {60'd0, b_bid_out}, {60'd0, exp_bid});
    endtask

    initial begin
        rst = 1'b1;
        aw_cmd_valid = 1'b0; aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        b_resp_free = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {63'd0, aw_cmd_ready}, 64'd0);
        chk("rst_wready", {63'd0, wready}, 64'd0);
        chk("rst_done", {63'd0, b_transfer_done}, 64'd0);
        chk("rst_status", {62'd0, b_status_out}, 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_cmd_ready", {63'd0, aw_cmd_ready}, 64'd1);
        wvalid = 1'b1;
        #1;
        chk("idle_wready", {63'd0, wready}, 64'd0);
        wvalid = 1'b0;

        // 1: INCR 0x10 len 3 -> words 4..7
        do_cmd(4'h5, 32'h10, 8'd3, 3'd2, 2'b01);
        do_beat("t1b0", 32'hA0, 1'b0, 1'b1, 4);
        do_beat("t1b1", 32'hA1, 1'b0, 1'b1, 5);
        do_beat("t1b2", 32'hA2, 1'b0, 1'b1, 6);
        do_beat("t1b3", 32'hA3, 1'b1, 1'b1, 7);
        check_resp("t1", 4'h5, 2'b00);

        // 2: WRAP 0x38 len 3 -> words 14,15,12,13
        do_cmd(4'hA, 32'h38, 8'd3, 3'd2, 2'b10);
        do_beat("t2b0", 32'hB0, 1'b0, 1'b1, 14);
        do_beat("t2b1", 32'hB1, 1'b0, 1'b1, 15);
        do_beat("t2b2", 32'hB2, 1'b0, 1'b1, 12);
        do_beat("t2b3", 32'hB3, 1'b1, 1'b1, 13);
        check_resp("t2", 4'hA, 2'b00);

        // 3: early wlast on beat 1 of a len-3 burst
        do_cmd(4'h3, 32'h100, 8'd3, 3'd2, 2'b01);
        do_beat("t3b0", 32'hC0, 1'b0, 1'b1, 64);
        do_beat("t3b1", 32'hC1, 1'b1, 1'b1, 65);
        check_resp("t3", 4'h3, 2'b10);

        // 4: INCR runs off the end of memory -> DECERR
        do_cmd(4'h7, 32'hFFC, 8'd1, 3'd2, 2'b01);
        do_beat("t4b0", 32'hD0, 1'b0, 1'b1, 1023);
        do_beat("t4b1", 32'hD1, 1'b1, 1'b0, 0);
        check_resp("t4", 4'h7, 2'b11);

        // Missing wlast on the final counted beat -> SLVERR, both beats written
        do_cmd(4'h9, 32'h200, 8'd1, 3'd2, 2'b01);
        do_beat("mlb0", 32'hE0, 1'b0, 1'b1, 128);
        do_beat("mlb1", 32'hE1, 1'b0, 1'b1, 129);
        check_resp("ml", 4'h9, 2'b10);

        // Oversized beat -> SLVERR at latch, nothing written
        do_cmd(4'h2, 32'h0, 8'd0, 3'd3, 2'b00);
        do_beat("szb0", 32'hF0, 1'b1, 1'b0, 0);
        check_resp("sz", 4'h2, 2'b10);

        // Unaligned WRAP -> SLVERR
        do_cmd(4'h4, 32'h2, 8'd1, 3'd2, 2'b10);
        do_beat("wub0", 32'h10, 1'b0, 1'b0, 0);
        do_beat("wub1", 32'h11, 1'b1, 1'b0, 0);
        check_resp("wu", 4'h4, 2'b10);

        // 5: response stage busy holds off the command
        b_resp_free = 1'b0;
        @(negedge clk);
        aw_id = 4'hC; aw_addr = 32'h20; aw_len = 8'd0; aw_size = 3'd2; aw_burst = 2'b00;
        aw_cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_blocked", {63'd0, aw_cmd_ready}, 64'd0);
            @(negedge clk);
        end
        b_resp_free = 1'b1;
        #1;
        chk("t5_ready", {63'd0, aw_cmd_ready}, 64'd1);
        @(posedge clk);
        #1;
        aw_cmd_valid = 1'b0;
        $display("[TB] cmd id=c accepted after b_resp_free");
        do_beat("t5b0", 32'h55, 1'b1, 1'b1, 8);
        check_resp("t5", 4'hC, 2'b00);

        // 6: reset during beat 2 of a len-7 burst
        do_cmd(4'h6, 32'h0, 8'd7, 3'd2, 2'b01);
        do_beat("t6b0", 32'h60, 1'b0, 1'b1, 0);
        do_beat("t6b1", 32'h61, 1'b0, 1'b1, 1);
        @(negedge clk);
        wvalid = 1'b1; wdata = 32'h62; wstrb = 4'hF; wlast = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_wready", {63'd0, wready}, 64'd0);
        chk("t6_we", {63'd0, mem_we}, 64'd0);
        chk("t6_cmd_ready", {63'd0, aw_cmd_ready}, 64'd0);
        chk("t6_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        $display("[TB] reset asserted mid-burst");
        @(negedge clk);
        rst = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_done", {63'd0, b_transfer_done}, 64'd0);
        end
        do_cmd(4'hE, 32'h40, 8'd0, 3'd2, 2'b01);
        do_beat("t6nb0", 32'h77, 1'b1, 1'b1, 16);
        check_resp("t6n", 4'hE, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
